// File: rtl/regfile_mp_if.sv
// Register-file bus: clear handshake, read ports and write ports.
// The requester (decode/writeback side) uses the master modport; the register file uses slave.
interface regfile_mp_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned REG_NUM    = 32,
    parameter int unsigned NUM_RD     = 2,
    parameter int unsigned NUM_WR     = 1
);
    localparam int unsigned ADDR_W = $clog2(REG_NUM);

    logic                                  clear_req;
    logic                                  ready;
    logic [NUM_RD-1:0][ADDR_W-1:0]         rd_num;
    logic [NUM_RD-1:0][DATA_WIDTH-1:0]     rd_data;
    logic [NUM_WR-1:0][ADDR_W-1:0]         wr_num;
    logic [NUM_WR-1:0][DATA_WIDTH-1:0]     wr_data;
    logic [NUM_WR-1:0]                     wr_en;
    logic                                  wr_conflict;

    modport master (
        output clear_req, rd_num, wr_num, wr_data, wr_en,
        input  ready, rd_data, wr_conflict
    );

    modport slave (
        input  clear_req, rd_num, wr_num, wr_data, wr_en,
        output ready, rd_data, wr_conflict
    );
endinterface

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with optional zero register, optional
// write-to-read bypass, highest-port-wins write priority and a sequential clear engine.
module regfile_mp #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned REG_NUM    = 32,
    parameter int unsigned NUM_RD     = 2,
    parameter int unsigned NUM_WR     = 1,
    parameter bit          ZERO_REG   = 1'b1,
    parameter bit          BYPASS     = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    regfile_mp_if.slave bus
);
    localparam int unsigned       ADDR_W  = $clog2(REG_NUM);
    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(REG_NUM - 1);

    typedef enum logic {StClear, StReady} state_e;

    // Storage has no reset; the clear engine zeroes it after every reset.
    logic [DATA_WIDTH-1:0]             r_mem [REG_NUM];
    state_e                            r_state;
    logic [ADDR_W-1:0]                 r_clr_idx;
    logic                              r_ready;
    logic                              r_wr_conflict;

    logic                              w_in_ready;
    logic [NUM_WR-1:0]                 w_wr_ok;
    logic                              w_conflict;
    logic [NUM_RD-1:0][DATA_WIDTH-1:0] w_rd_data;

    assign w_in_ready = (r_state == StReady);

    // A write port is live only in READY, when enabled, and not aimed at a hardwired zero.
    always_comb begin
        w_wr_ok = '0;
        for (int p = 0; p < NUM_WR; p++) begin
            w_wr_ok[p] = w_in_ready && bus.wr_en[p] &&
                         !(ZERO_REG && (bus.wr_num[p] == '0));
        end
    end

    // Flag any pair of live write ports that target the same register.
    always_comb begin
        w_conflict = 1'b0;
        for (int i = 0; i < NUM_WR; i++) begin
            for (int j = i + 1; j < NUM_WR; j++) begin
                if (w_wr_ok[i] && w_wr_ok[j] && (bus.wr_num[i] == bus.wr_num[j])) begin
                    w_conflict = 1'b1;
                end
            end
        end
    end

    // Clear engine FSM with registered ready and conflict flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= StClear;
            r_clr_idx     <= '0;
            r_ready       <= 1'b0;
            r_wr_conflict <= 1'b0;
        end else begin
            unique case (r_state)
                StClear: begin
                    // clear_req is deliberately ignored here: no restart mid-clear.
                    r_clr_idx     <= r_clr_idx + ADDR_W'(1);
                    r_wr_conflict <= 1'b0;
                    if (r_clr_idx == LastIdx) begin
                        r_state <= StReady;
                        r_ready <= 1'b1;
                    end
                end
                StReady: begin
                    r_wr_conflict <= w_conflict;
                    if (bus.clear_req) begin
                        r_state   <= StClear;
                        r_clr_idx <= '0;
                        r_ready   <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Storage update: one zeroed entry per cycle in CLEAR, else the live ports in
    // ascending order so the highest-index port wins a same-address collision.
    always_ff @(posedge clk) begin
        if (r_state == StClear) begin
            r_mem[r_clr_idx] <= '0;
        end else begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (w_wr_ok[p]) begin
                    r_mem[bus.wr_num[p]] <= bus.wr_data[p];
                end
            end
        end
    end

    // Combinational read ports; bypass uses the same priority as the write path.
    always_comb begin
        w_rd_data = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            if (w_in_ready && !(ZERO_REG && (bus.rd_num[r] == '0))) begin
                w_rd_data[r] = r_mem[bus.rd_num[r]];
                if (BYPASS) begin
                    for (int p = 0; p < NUM_WR; p++) begin
                        if (w_wr_ok[p] && (bus.wr_num[p] == bus.rd_num[r])) begin
                            w_rd_data[r] = bus.wr_data[p];
                        end
                    end
                end
            end
        end
    end

    assign bus.ready       = r_ready;
    assign bus.wr_conflict = r_wr_conflict;
    assign bus.rd_data     = w_rd_data;
endmodule
